moore_seq_detector: RTL
=======================

Name: moore_seq_detector

Overview:
- Parametrised Moore-type serial pattern detector.
- Successor to the fixed 2-bit-state, 4-state Moore models used in the sequential class set.
- Matches a configurable PATTERN_W-bit pattern on serial input x_in, MSB first, with selectable overlapping or non-overlapping detection.
- Exposes its state register for structural/behavioural cross-checking and keeps a saturating match counter.

Parameters:
- PATTERN_W, 4, pattern length in bits; legal 2..16.
- PATTERN, 4'b1011, pattern to match; bit PATTERN_W-1 is received first.
- OVERLAP, 1, 1 = overlapping detection, 0 = non-overlapping (restart after match).
- CNT_W, 8, width of match counter.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- x_in  input  1  serial data bit, sampled on rising clock edge.
- en  input  1  shift enable; when 0 the state holds.
- clr_cnt  input  1  synchronous clear of match_cnt.
- y_out  output  1  Moore detect output; function of state only.
- state  output  SW=$clog2(PATTERN_W+1)  current state = number of pattern bits currently matched.
- match_cnt  output  CNT_W  saturating count of detections.

Behaviour:
- Reset (reset=0, asynchronous, immediate, also mid-operation): state=0, y_out=0, match_cnt=0. Outputs are held while reset is low.
- States S0..S(PATTERN_W). Sk means the last k received bits equal the top k bits of PATTERN. S(PATTERN_W) is the detect state.
- y_out = (state == PATTERN_W). Purely decoded from the state register; no combinational path from x_in.
- Detection latency: y_out rises in the cycle after the edge that samples the final pattern bit. It stays high one cycle per detection unless the next bits re-enter the detect state.
- Transition, en=1, from Sk with k<PATTERN_W and bit b: next = longest j ≤ k+1 such that the top j PATTERN bits equal the last j bits of (matched prefix, b). This is the KMP failure rule, computed at elaboration; there is no runtime table.
- Transition from S(PATTERN_W):
  - OVERLAP=1: same rule, applied to the full pattern followed by b.
  - OVERLAP=0: next = S1 if b == PATTERN[PATTERN_W-1], else S0.
- en=0: state, y_out and match_cnt hold; x_in is ignored.
- match_cnt increments on the edge where next_state == PATTERN_W and en=1.
- match_cnt saturates at 2^CNT_W-1; it does not wrap.
- clr_cnt=1: match_cnt <= 0 on the next edge. If a detection occurs on the same edge, clear wins and the result is 0. clr_cnt does not affect state.
- Out-of-range state encodings (> PATTERN_W) recover to S0 on the next enabled edge. y_out=0 in those encodings.
- Illegal parameters: PATTERN_W outside 2..16 stops elaboration via $error.

Test Plan:
1. Reset/idle: hold reset=0 for 2 edges, release with x_in=0. Required: state=0, y_out=0, match_cnt=0 throughout.
2. Overlap detect: PATTERN=1011, OVERLAP=1, en=1, feed 1,0,1,1,0,1,1. Required state sequence 1,2,3,4,2,3,4. y_out high after the 4th and 7th edges. match_cnt=2.
3. Non-overlap: same stream with OVERLAP=0. Required state sequence 1,2,3,4,0,1,1. Single y_out pulse after the 4th edge. match_cnt=1.
4. Enable gating: in stream 2, drop en for 3 cycles after the 2nd bit while toggling x_in. Required: state holds at 2 and detection resumes correctly. match_cnt=2 at end.
5. Counter saturation and clear: CNT_W=2, feed 1011 repeated 5 times. Required: match_cnt=3 and stays 3. Then assert clr_cnt on the same edge as a detection. Required: match_cnt=0 and y_out=1 in the following cycle.
6. Async reset mid-pattern: after bits 1,0,1 (state=3), pulse reset low between clock edges. Required: state=0 and match_cnt=0 immediately, without waiting for a clock edge. Then bit 1 gives state=1, not 4.

Source files
------------

// File: rtl/moore_seq_detector.sv
// -----------------------------------------------------------------------------
// moore_seq_detector
//
// Parametrised Moore serial pattern detector. Bits arrive MSB-first on x_in;
// the state register holds the number of pattern bits currently matched
// (0..PATTERN_W). Reaching PATTERN_W raises y_out for that state and bumps a
// saturating match counter. Overlapping or restart-after-match detection is
// chosen by OVERLAP.
//
// Ports:
//   clock     - rising-edge system clock
//   reset     - asynchronous, active-low reset
//   x_in      - serial data bit, sampled on the rising edge
//   en        - shift enable; when low the state and counter hold
//   clr_cnt   - synchronous clear of match_cnt (wins over a same-edge match)
//   y_out     - detect flag, decoded from the state register only
//   state     - current matched-prefix length
//   match_cnt - saturating count of detections
// -----------------------------------------------------------------------------
module moore_seq_detector #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             x_in,
  input  logic                             en,
  input  logic                             clr_cnt,
  output logic                             y_out,
  output logic [$clog2(PATTERN_W+1)-1:0]   state,
  output logic [CNT_W-1:0]                 match_cnt
);

  localparam int SW = $clog2(PATTERN_W + 1);

  // The state space scales with PATTERN_W, so states are plain encoded
  // prefix lengths rather than enum members; only the endpoints are named.
  typedef logic [SW-1:0] state_t;

  localparam state_t              S_IDLE  = '0;
  localparam state_t              S_MATCH = SW'(PATTERN_W);
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;

  if (PATTERN_W < 2 || PATTERN_W > 16) begin : g_bad_pattern_w
    $error("moore_seq_detector: PATTERN_W must be in 2..16");
  end

  // Longest prefix of PATTERN that is a suffix of (first k pattern bits, b).
  // From the full-match state with OVERLAP=0, history is discarded and only
  // the new bit can start a fresh match.
  function automatic int next_match(input int k, input logic b);
    int   len;
    int   jmax;
    int   pos;
    int   result;
    logic ok;
    logic s_bit;
    result = 0;
    if (k >= PATTERN_W && !OVERLAP) begin
      if (b == PATTERN[PATTERN_W-1]) result = 1;
    end else begin
      len  = k + 1;
      jmax = (len > PATTERN_W) ? PATTERN_W : len;
      for (int j = 1; j <= jmax; j++) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          pos = len - j + i;
          if (pos < k) s_bit = PATTERN[PATTERN_W-1-pos];
          else         s_bit = b;
          if (s_bit != PATTERN[PATTERN_W-1-i]) ok = 1'b0;
        end
        if (ok) result = j;
      end
    end
    return result;
  endfunction

  // Per-state successors, folded to constants during elaboration.
  state_t nxt_on0 [PATTERN_W+1];
  state_t nxt_on1 [PATTERN_W+1];

  for (genvar k = 0; k <= PATTERN_W; k++) begin : g_next
    localparam int N0 = next_match(k, 1'b0);
    localparam int N1 = next_match(k, 1'b1);
    assign nxt_on0[k] = SW'(N0);
    assign nxt_on1[k] = SW'(N1);
  end

  state_t            state_q,     state_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d     = state_q;
    match_cnt_d = match_cnt_q;

    if (en) begin
      // Encodings above S_MATCH match no entry and fall back to S_IDLE.
      state_d = S_IDLE;
      for (int k = 0; k <= PATTERN_W; k++) begin
        if (state_q == SW'(k)) state_d = x_in ? nxt_on1[k] : nxt_on0[k];
      end
    end

    if (clr_cnt) begin
      match_cnt_d = '0;
    end else if (en && state_d == S_MATCH && match_cnt_q != CNT_MAX) begin
      match_cnt_d = match_cnt_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign y_out     = (state_q == S_MATCH);
  assign state     = state_q;
  assign match_cnt = match_cnt_q;

endmodule
